// File: rtl/watch_pkg.sv
// Shared types, field widths and wrap helpers for the watch alarm controller.
package watch_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   function automatic logic [HOUR_W-1:0] hour_step(input logic [HOUR_W-1:0] h, input logic up);
      if (up) return (h >= HOUR_MAX) ? '0 : h + 1'b1;
      else    return (h == '0) ? HOUR_MAX : h - 1'b1;
   endfunction

   function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] m, input logic up);
      if (up) return (m >= MIN_MAX) ? '0 : m + 1'b1;
      else    return (m == '0) ? MIN_MAX : m - 1'b1;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave buzzer tone: toggles o_tone every HALF_PERIOD clocks while en is high.
module tone_gen #(
   parameter int HALF_PERIOD = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic o_tone
);

   localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   // Dropping en clears both the divider and the tone, so every ring starts low.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt    <= '0;
         o_tone <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         o_tone <= ~o_tone;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/watch_alarm.sv
// Alarm controller: stores the alarm time, rings on the matching minute, supports
// stop, snooze and ring timeout, and drives a buzzer tone while ringing.
//
// state  | meaning
// IDLE   | armed or disarmed, waiting for the alarm time; alarm time editable
// RING   | alarm sounding, tone running, counting seconds toward timeout
// SNOOZE | silenced, waiting for the latched snooze target time
module watch_alarm
   import watch_pkg::*;
#(
   parameter int FCLK         = 100_000_000,
   parameter int TONE_HZ      = 1000,
   parameter int RING_SEC     = 60,
   parameter int SNOOZE_MIN   = 5,
   parameter int AL_HOUR_INIT = 7,
   parameter int AL_MIN_INIT  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        hour,
   input  logic [5:0]        min,
   input  logic [5:0]        sec,
   input  logic              alarm_en,
   input  logic              set_mode,
   input  logic              i_up,
   input  logic              i_down,
   input  logic              i_sel,
   input  logic              i_stop,
   input  logic              i_snooze,
   output logic [4:0]        al_hour,
   output logic [5:0]        al_min,
   output logic              o_ringing,
   output logic              o_snoozed,
   output logic              o_buzz,
   output logic              o_sel_hour
);

   localparam int HALF_PERIOD = (FCLK / (2 * TONE_HZ) > 0) ? FCLK / (2 * TONE_HZ) : 1;
   localparam int RING_W      = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
   localparam logic [RING_W-1:0] RING_LAST  = RING_W'(RING_SEC - 1);
   localparam logic [MIN_W:0]    SNOOZE_ADD = (MIN_W+1)'(SNOOZE_MIN);
   localparam logic [MIN_W:0]    MIN_WRAP   = (MIN_W+1)'(60);

   state_t              state_q, state_d;
   logic                time_valid;
   logic                match, match_q, trig;
   logic                sn_match, sn_match_q, sn_trig;
   logic [SEC_W-1:0]    sec_q;
   logic                sec_chg;
   logic [RING_W-1:0]   ring_cnt;
   logic                ring_done;
   logic [HOUR_W-1:0]   sn_hour, sn_hour_d;
   logic [MIN_W-1:0]    sn_min, sn_min_d;
   logic [MIN_W:0]      sum_min;
   logic                edit_en;
   logic                tone_en;

   assign time_valid = (hour <= HOUR_MAX) && (min <= MIN_MAX);
   assign match      = time_valid && (hour == al_hour) && (min == al_min) && (sec == '0);
   assign sn_match   = time_valid && (hour == sn_hour) && (min == sn_min) && (sec == '0);
   assign trig       = match && !match_q;
   assign sn_trig    = sn_match && !sn_match_q;
   assign sec_chg    = (sec != sec_q);
   assign ring_done  = sec_chg && (ring_cnt == RING_LAST);
   assign edit_en    = set_mode && (state_q == IDLE);

   // Snooze target: minutes carry into the hour, the hour wraps at midnight.
   always_comb begin
      sum_min   = {1'b0, min} + SNOOZE_ADD;
      sn_hour_d = hour;
      sn_min_d  = sum_min[MIN_W-1:0];
      if (sum_min > {1'b0, MIN_MAX}) begin
         sn_min_d  = MIN_W'(sum_min - MIN_WRAP);
         sn_hour_d = hour_step(hour, 1'b1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (trig && !set_mode) state_d = RING;
         RING: begin
            if (i_stop)         state_d = IDLE;
            else if (i_snooze)  state_d = SNOOZE;
            else if (ring_done) state_d = IDLE;
         end
         SNOOZE: begin
            if (i_stop)       state_d = IDLE;
            else if (sn_trig) state_d = RING;
         end
         default: state_d = IDLE;
      endcase
      if (!alarm_en) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         o_ringing  <= 1'b0;
         o_snoozed  <= 1'b0;
         match_q    <= 1'b1;
         sn_match_q <= 1'b1;
         sec_q      <= sec;
         ring_cnt   <= '0;
         sn_hour    <= '0;
         sn_min     <= '0;
      end else begin
         state_q    <= state_d;
         o_ringing  <= (state_d == RING);
         o_snoozed  <= (state_d == SNOOZE);
         match_q    <= match;
         sn_match_q <= sn_match;
         sec_q      <= sec;
         if (state_q != RING)
            ring_cnt <= '0;
         else if (sec_chg && !ring_done)
            ring_cnt <= ring_cnt + 1'b1;
         if (state_q == RING && state_d == SNOOZE) begin
            sn_hour <= sn_hour_d;
            sn_min  <= sn_min_d;
         end
      end
   end

   // Simultaneous up and down cancel; the field selected before any i_sel is edited.
   always_ff @(posedge clk) begin
      if (rst) begin
         al_hour    <= HOUR_W'(AL_HOUR_INIT);
         al_min     <= MIN_W'(AL_MIN_INIT);
         o_sel_hour <= 1'b0;
      end else if (edit_en) begin
         if (i_up ^ i_down) begin
            if (o_sel_hour) al_hour <= hour_step(al_hour, i_up);
            else            al_min  <= min_step(al_min, i_up);
         end
         if (i_sel) o_sel_hour <= ~o_sel_hour;
      end
   end

   // Tone runs only while RING persists across the edge, so it drops with the state.
   assign tone_en = (state_q == RING) && (state_d == RING);

   tone_gen #(
      .HALF_PERIOD(HALF_PERIOD)
   ) u_tone_gen (
      .clk    (clk),
      .rst    (rst),
      .en     (tone_en),
      .o_tone (o_buzz)
   );

endmodule

// File: tb/tb_watch_alarm.sv
// Self-checking bench for watch_alarm: directed scenarios plus a randomized run
// against a time-of-day reference model.
module tb_watch_alarm;

   localparam int HP   = 5;
   localparam int RSEC = 3;
   localparam int SNZ  = 5;
   localparam int ST_I = 0;
   localparam int ST_R = 1;
   localparam int ST_S = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic       alarm_en, set_mode, i_up, i_down, i_sel, i_stop, i_snooze;
   logic [4:0] al_hour;
   logic [5:0] al_min;
   logic       o_ringing, o_snoozed, o_buzz, o_sel_hour;

   int n_cmp = 0;
   int n_err = 0;

   int m_state, m_al_h, m_al_m, m_prev_sec, m_rsecs, m_age, m_sn_tod;
   bit m_sel, m_prev_match, m_prev_sn;

   always #5 clk = ~clk;

   watch_alarm #(
      .FCLK(1000), .TONE_HZ(100), .RING_SEC(RSEC), .SNOOZE_MIN(SNZ),
      .AL_HOUR_INIT(7), .AL_MIN_INIT(0)
   ) dut (
      .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec),
      .alarm_en(alarm_en), .set_mode(set_mode),
      .i_up(i_up), .i_down(i_down), .i_sel(i_sel), .i_stop(i_stop), .i_snooze(i_snooze),
      .al_hour(al_hour), .al_min(al_min),
      .o_ringing(o_ringing), .o_snoozed(o_snoozed), .o_buzz(o_buzz), .o_sel_hour(o_sel_hour)
   );

   // Reference model: advances one clock using the present inputs.
   function automatic void model_step();
      int  nxt, tod, step;
      bit  valid, match, sn_match, secchg;
      valid    = (int'(hour) <= 23) && (int'(min) <= 59);
      tod      = int'(hour) * 60 + int'(min);
      match    = valid && int'(hour) == m_al_h && int'(min) == m_al_m && sec == 6'd0;
      sn_match = valid && tod == m_sn_tod && sec == 6'd0;
      secchg   = int'(sec) != m_prev_sec;
      if (rst) begin
         m_state = ST_I; m_al_h = 7; m_al_m = 0; m_sel = 1'b0;
         m_prev_match = 1'b1; m_prev_sn = 1'b1; m_prev_sec = int'(sec);
         m_rsecs = 0; m_age = 0; m_sn_tod = 0;
         return;
      end
      nxt = m_state;
      if (!alarm_en) nxt = ST_I;
      else if (m_state == ST_I) begin
         if (match && !m_prev_match && !set_mode) nxt = ST_R;
      end else if (m_state == ST_R) begin
         if (i_stop) nxt = ST_I;
         else if (i_snooze) begin
            nxt = ST_S;
            m_sn_tod = (tod + SNZ) % 1440;
         end else if (secchg && m_rsecs + 1 >= RSEC) nxt = ST_I;
      end else begin
         if (i_stop) nxt = ST_I;
         else if (sn_match && !m_prev_sn) nxt = ST_R;
      end
      if (m_state == ST_I && set_mode) begin
         step = (i_up && !i_down) ? 1 : (i_down && !i_up) ? -1 : 0;
         if (m_sel) m_al_h = (m_al_h + step + 24) % 24;
         else       m_al_m = (m_al_m + step + 60) % 60;
         if (i_sel) m_sel = !m_sel;
      end
      if (m_state == ST_R && nxt == ST_R) begin
         m_rsecs = m_rsecs + (secchg ? 1 : 0);
         m_age   = m_age + 1;
      end else begin
         m_rsecs = 0;
         m_age   = 0;
      end
      m_prev_match = match;
      m_prev_sn    = sn_match;
      m_prev_sec   = int'(sec);
      m_state      = nxt;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      hour = 5'(h); min = 6'(m); sec = 6'(s);
   endtask

   task automatic ring_at_0700();
      set_time(6, 59, 59); tick();
      set_time(7, 0, 0);   tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; alarm_en = 1'b1; set_mode = 1'b0;
      i_up = 1'b0; i_down = 1'b0; i_sel = 1'b0; i_stop = 1'b0; i_snooze = 1'b0;
      set_time(7, 0, 0);
      tick(); tick();
      n_cmp++;
      if ({o_ringing, o_snoozed, o_buzz, o_sel_hour} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got %b expected 0000", {o_ringing, o_snoozed, o_buzz, o_sel_hour});
      end
      n_cmp++;
      if ({al_hour, al_min} !== {5'd7, 6'd0}) begin
         n_err++; $display("FAIL reset_alarm_time: got %0d:%0d expected 7:0", al_hour, al_min);
      end
      rst = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (o_ringing !== 1'b0) begin
         n_err++; $display("FAIL reset_at_match_no_ring: got %b expected 0", o_ringing);
      end
   endtask

   task automatic test_ring_buzz();
      logic exp_b;
      set_time(6, 59, 59); tick();
      n_cmp++;
      if (o_ringing !== 1'b0) begin
         n_err++; $display("FAIL ring_before_match: got %b expected 0", o_ringing);
      end
      set_time(7, 0, 0); tick();
      n_cmp++;
      if ({o_ringing, o_buzz} !== 2'b10) begin
         n_err++; $display("FAIL ring_rise: got %b expected 10", {o_ringing, o_buzz});
      end
      for (int k = 1; k <= 24; k++) begin
         tick();
         exp_b = ((k / HP) % 2) == 1;
         n_cmp++;
         if ({o_ringing, o_buzz} !== {1'b1, exp_b}) begin
            n_err++; $display("FAIL buzz_cycle_%0d: got %b expected %b", k, {o_ringing, o_buzz}, {1'b1, exp_b});
         end
      end
   endtask

   task automatic test_stop();
      i_stop = 1'b1; tick(); i_stop = 1'b0;
      n_cmp++;
      if ({o_ringing, o_buzz} !== 2'b00) begin
         n_err++; $display("FAIL stop: got %b expected 00", {o_ringing, o_buzz});
      end
      for (int s = 0; s < 6; s++) begin
         set_time(7, 0, (s < 3) ? 0 : s);
         tick();
         n_cmp++;
         if (o_ringing !== 1'b0) begin
            n_err++; $display("FAIL stop_no_retrigger_%0d: got %b expected 0", s, o_ringing);
         end
      end
   endtask

   task automatic test_snooze();
      ring_at_0700();
      set_time(7, 0, 20); tick();
      i_snooze = 1'b1; tick(); i_snooze = 1'b0;
      n_cmp++;
      if ({o_ringing, o_snoozed, o_buzz} !== 3'b010) begin
         n_err++; $display("FAIL snooze_enter: got %b expected 010", {o_ringing, o_snoozed, o_buzz});
      end
      set_time(7, 4, 59); tick();
      set_time(7, 5, 0);  tick();
      n_cmp++;
      if ({o_ringing, o_snoozed} !== 2'b10) begin
         n_err++; $display("FAIL snooze_rering_0705: got %b expected 10", {o_ringing, o_snoozed});
      end
      i_stop = 1'b1; tick(); i_stop = 1'b0;
   endtask

   task automatic test_timeout();
      ring_at_0700();
      for (int s = 1; s <= 2; s++) begin
         set_time(7, 0, s); tick(); tick();
         n_cmp++;
         if (o_ringing !== 1'b1) begin
            n_err++; $display("FAIL timeout_early_%0d: got %b expected 1", s, o_ringing);
         end
      end
      set_time(7, 0, 3); tick();
      n_cmp++;
      if ({o_ringing, o_buzz} !== 2'b00) begin
         n_err++; $display("FAIL timeout_end: got %b expected 00", {o_ringing, o_buzz});
      end
   endtask

   task automatic test_disable_priority();
      ring_at_0700();
      repeat (7) tick();
      alarm_en = 1'b0; i_snooze = 1'b1; tick(); i_snooze = 1'b0; alarm_en = 1'b1;
      n_cmp++;
      if ({o_ringing, o_snoozed, o_buzz} !== 3'b000) begin
         n_err++; $display("FAIL disable_in_ring: got %b expected 000", {o_ringing, o_snoozed, o_buzz});
      end
      ring_at_0700();
      i_stop = 1'b1; i_snooze = 1'b1; tick(); i_stop = 1'b0; i_snooze = 1'b0;
      n_cmp++;
      if ({o_ringing, o_snoozed} !== 2'b00) begin
         n_err++; $display("FAIL stop_over_snooze: got %b expected 00", {o_ringing, o_snoozed});
      end
      ring_at_0700();
      i_snooze = 1'b1; tick(); i_snooze = 1'b0;
      alarm_en = 1'b0; tick(); alarm_en = 1'b1;
      n_cmp++;
      if ({o_ringing, o_snoozed} !== 2'b00) begin
         n_err++; $display("FAIL disable_in_snooze: got %b expected 00", {o_ringing, o_snoozed});
      end
   endtask

   task automatic test_edit();
      set_time(12, 34, 56); set_mode = 1'b1;
      i_down = 1'b1; tick(); i_down = 1'b0;
      i_up = 1'b1; tick(); i_up = 1'b0;
      n_cmp++;
      if ({al_hour, al_min} !== {5'd7, 6'd0}) begin
         n_err++; $display("FAIL edit_min_wrap_up: got %0d:%0d expected 7:0", al_hour, al_min);
      end
      i_sel = 1'b1; tick(); i_sel = 1'b0;
      n_cmp++;
      if (o_sel_hour !== 1'b1) begin
         n_err++; $display("FAIL edit_sel: got %b expected 1", o_sel_hour);
      end
      repeat (8) begin i_down = 1'b1; tick(); i_down = 1'b0; end
      n_cmp++;
      if ({al_hour, al_min} !== {5'd23, 6'd0}) begin
         n_err++; $display("FAIL edit_hour_wrap_down: got %0d:%0d expected 23:0", al_hour, al_min);
      end
      i_up = 1'b1; i_down = 1'b1; tick(); i_up = 1'b0; i_down = 1'b0;
      n_cmp++;
      if ({al_hour, al_min} !== {5'd23, 6'd0}) begin
         n_err++; $display("FAIL edit_up_down_cancel: got %0d:%0d expected 23:0", al_hour, al_min);
      end
      i_sel = 1'b1; tick(); i_sel = 1'b0;
      repeat (2) begin i_down = 1'b1; tick(); i_down = 1'b0; end
      set_mode = 1'b0;
      i_up = 1'b1; tick(); i_up = 1'b0;
      n_cmp++;
      if ({al_hour, al_min, o_sel_hour} !== {5'd23, 6'd58, 1'b0}) begin
         n_err++; $display("FAIL edit_final_and_locked: got %0d:%0d sel %b expected 23:58 sel 0", al_hour, al_min, o_sel_hour);
      end
   endtask

   task automatic test_snooze_wrap();
      set_time(23, 57, 59); tick();
      set_time(23, 58, 0);  tick();
      i_snooze = 1'b1; tick(); i_snooze = 1'b0;
      set_time(0, 2, 59); tick();
      n_cmp++;
      if ({o_ringing, o_snoozed} !== 2'b01) begin
         n_err++; $display("FAIL snooze_wrap_wait: got %b expected 01", {o_ringing, o_snoozed});
      end
      set_time(0, 3, 0); tick();
      n_cmp++;
      if ({o_ringing, o_snoozed} !== 2'b10) begin
         n_err++; $display("FAIL snooze_wrap_0003: got %b expected 10", {o_ringing, o_snoozed});
      end
      i_stop = 1'b1; tick(); i_stop = 1'b0;
   endtask

   task automatic test_random();
      logic [14:0] exp_v, got_v;
      int pick, h, m, len;
      bit valid;
      for (int seg = 0; seg < 400; seg++) begin
         pick = $urandom_range(0, 9);
         if (pick < 4)      begin h = m_al_h; m = m_al_m; end
         else if (pick < 7) begin h = m_sn_tod / 60; m = m_sn_tod % 60; end
         else if (pick < 8) begin h = $urandom_range(20, 31); m = $urandom_range(55, 63); end
         else               begin h = $urandom_range(0, 23); m = $urandom_range(0, 59); end
         set_time(h, m, $urandom_range(0, 3));
         valid    = (h <= 23) && (m <= 59);
         alarm_en = ($urandom_range(0, 29) != 0);
         set_mode = ($urandom_range(0, 5) == 0);
         len = $urandom_range(1, 10);
         for (int c = 0; c < len; c++) begin
            rst      = ($urandom_range(0, 499) == 0);
            i_up     = ($urandom_range(0, 7) == 0);
            i_down   = ($urandom_range(0, 7) == 0);
            i_sel    = ($urandom_range(0, 9) == 0);
            i_stop   = ($urandom_range(0, 19) == 0);
            i_snooze = valid && ($urandom_range(0, 9) == 0);
            tick();
            exp_v = {5'(m_al_h), 6'(m_al_m), m_sel, m_state == ST_R, m_state == ST_S,
                     (m_state == ST_R) && ((m_age / HP) % 2 == 1)};
            got_v = {al_hour, al_min, o_sel_hour, o_ringing, o_snoozed, o_buzz};
            n_cmp++;
            if (got_v !== exp_v) begin
               n_err++; $display("FAIL random_seg%0d_cyc%0d: got %h expected %h", seg, c, got_v, exp_v);
            end
         end
      end
      rst = 1'b0; i_up = 1'b0; i_down = 1'b0; i_sel = 1'b0; i_stop = 1'b0; i_snooze = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ring_buzz();
      test_stop();
      test_snooze();
      test_timeout();
      test_disable_priority();
      test_edit();
      test_snooze_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
